// File: rtl/ram_16x16.sv
`default_nettype none
// ============================================================================
// Module   : ram_16x16
// Brief    : 16x16 single-bit video frame memory, row-major (y*16+x),
//            synchronous write with write-through, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module ram_16x16 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       write_enable,
  input  logic       write_data,
  output logic       read_data
);

  localparam int unsigned DEPTH = 256;

  logic [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] mem_d;
  logic             rd_q;
  logic             rd_d;
  logic [7:0]       addr;

  // Row-major linear index: y selects the row of 16 pixels, x the column.
  assign addr = {y, x};

  always_comb begin
    mem_d = mem_q;
    rd_d  = mem_q[addr];
    if (write_enable) begin
      mem_d[addr] = write_data;
      rd_d        = write_data;
    end
  end

  // Reset takes priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign read_data = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_16x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_16x16
// Brief    : Self-checking bench for ram_16x16 against an array frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_16x16;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic       write_enable;
  logic       write_data;
  logic       read_data;

  int total = 0;
  int bad   = 0;

  // Frame model indexed as [row][column].
  bit frame [16][16];

  ram_16x16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access cycle; returns the value read_data must show after the edge.
  task automatic access(input int ax, input int ay, input bit we, input bit wd,
                        output bit exp);
    @(negedge clk);
    rst_n        = 1'b1;
    x            = 4'(ax);
    y            = 4'(ay);
    write_enable = we;
    write_data   = wd;
    @(posedge clk);
    #1;
    if (we) begin
      frame[ay][ax] = wd;
      exp = wd;
    end else begin
      exp = frame[ay][ax];
    end
  endtask

  task automatic do_reset(input bit we, input bit wd, input int ax, input int ay);
    @(negedge clk);
    rst_n        = 1'b0;
    x            = 4'(ax);
    y            = 4'(ay);
    write_enable = we;
    write_data   = wd;
    @(posedge clk);
    #1;
    foreach (frame[r, c]) frame[r][c] = 1'b0;
  endtask

  task automatic test_reset;
    bit exp;
    int errs = 0;
    do_reset(1'b0, 1'b0, 0, 0);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL reset_rd: got %b want 0", read_data);
    end
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        access(xx, yy, 1'b0, 1'b0, exp);
        if (read_data !== 1'b0) errs++;
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_clear: %0d pixels nonzero, want 0", errs);
    end
  endtask

  task automatic test_write_read;
    bit exp;
    access(1, 2, 1'b1, 1'b1, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL wr_thru_1_2: got %b want 1", read_data);
    end
    access(1, 2, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL rd_1_2: got %b want 1", read_data);
    end
    access(2, 1, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL rd_2_1_noswap: got %b want 0", read_data);
    end
  endtask

  task automatic test_second;
    bit exp;
    access(4, 5, 1'b1, 1'b1, exp);
    access(4, 5, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL rd_4_5: got %b want 1", read_data);
    end
    access(1, 2, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL rd_1_2_kept: got %b want 1", read_data);
    end
    access(5, 4, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL rd_5_4: got %b want 0", read_data);
    end
  endtask

  task automatic test_corners;
    bit exp;
    access(15, 15, 1'b1, 1'b1, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL wr_thru_15_15: got %b want 1", read_data);
    end
    access(15, 15, 1'b1, 1'b0, exp);
    access(15, 15, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL clear_15_15: got %b want 0", read_data);
    end
    access(0, 0, 1'b1, 1'b1, exp);
    access(15, 0, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL rd_15_0: got %b want 0", read_data);
    end
    access(0, 0, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b1) begin
      bad++;
      $display("FAIL rd_0_0: got %b want 1", read_data);
    end
  endtask

  task automatic test_reset_priority;
    bit exp;
    int errs = 0;
    do_reset(1'b1, 1'b1, 3, 3);
    access(3, 3, 1'b0, 1'b0, exp);
    total++;
    if (read_data !== 1'b0) begin
      bad++;
      $display("FAIL rst_prio_3_3: got %b want 0", read_data);
    end
    for (int i = 0; i < 40; i++)
      access($urandom_range(15), $urandom_range(15), 1'b1, 1'b1, exp);
    do_reset(1'b0, 1'b0, 0, 0);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        access(xx, yy, 1'b0, 1'b0, exp);
        if (read_data !== 1'b0) errs++;
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rst_discard: %0d pixels nonzero, want 0", errs);
    end
  endtask

  task automatic test_checkerboard;
    bit exp;
    int errs = 0;
    do_reset(1'b0, 1'b0, 0, 0);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        if (((xx + yy) % 2) == 1) access(xx, yy, 1'b1, 1'b1, exp);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        access(xx, yy, 1'b0, 1'b0, exp);
        if (read_data !== 1'(((xx + yy) % 2))) begin
          errs++;
          if (errs <= 4)
            $display("FAIL checker(%0d,%0d): got %b want %0d", xx, yy, read_data, (xx + yy) % 2);
        end
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL checkerboard: %0d pixel errors, want 0", errs);
    end
  endtask

  task automatic test_random;
    bit exp;
    int errs = 0;
    int ax, ay;
    bit we, wd;
    for (int i = 0; i < 600; i++) begin
      ax = $urandom_range(15);
      ay = $urandom_range(15);
      we = ($urandom_range(2) == 0);
      wd = 1'($urandom);
      access(ax, ay, we, wd, exp);
      if (read_data !== exp) begin
        errs++;
        if (errs <= 4)
          $display("FAIL random(%0d,%0d,we=%b): got %b want %b", ax, ay, we, read_data, exp);
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL random_ops: %0d errors, want 0", errs);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    x            = '0;
    y            = '0;
    write_enable = 1'b0;
    write_data   = 1'b0;
    test_reset();
    test_write_read();
    test_second();
    test_corners();
    test_reset_priority();
    test_checkerboard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_16x16.md
Name: ram_16x16

Overview:
- 16x16 single-bit video memory (256 pixels), addressed by (x, y) coordinates.
- Sits between the game/pixel-update logic (the writer) and the display scan-out path (the reader).
- One shared address port, synchronous write, registered read.
- Synchronous reset clears the whole frame.

Parameters:
- None. Geometry is fixed at 16 columns x 16 rows x 1 bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- x  input  4  column address, 0..15.
- y  input  4  row address, 0..15.
- write_enable  input  1  when 1, write write_data to pixel (x, y) this cycle.
- write_data  input  1  pixel value to store.
- read_data  output  1  registered pixel value at (x, y).

Behaviour:
- Interface: one clock, clk. Reset is rst_n, synchronous and active-low.
- Storage: 256 bits. Linear index = y*16 + x (row-major). Every (x, y) pair is valid, so there is no out-of-range case.
- Reset (rst_n=0 at a rising edge):
  - all 256 pixels cleared to 0;
  - read_data cleared to 0;
  - write_enable is ignored that cycle (reset wins over a simultaneous write).
  - Reset asserted mid-operation discards all prior contents.
- Write (rst_n=1, write_enable=1 at a rising edge):
  - mem[y*16+x] <= write_data;
  - read_data <= write_data (write-through: the new value is visible on the next cycle);
  - all other pixels unchanged.
- Read (rst_n=1, write_enable=0 at a rising edge):
  - read_data <= mem[y*16+x];
  - memory unchanged.
- Latency:
  - read_data reflects the address and data sampled at the most recent rising edge (1-cycle registered read).
  - No combinational path from x/y/write_data to read_data.
- Back-to-back timing:
  - Write (x, y) on edge N, read (x, y) on edge N+1: returns the written value.
  - Consecutive reads of different addresses give one result per cycle.
- Write of 0 clears a pixel. Rewriting the same value is harmless.
- Before the first reset, memory contents and read_data are unspecified. Scan-out logic must not rely on them.
- No handshake: the block is always ready and every cycle is a valid access.

Test Plan:
- Reset clear: drive rst_n=0 for one edge, then rst_n=1 and read every (x, y) with write_enable=0 -> read_data=0 for all 256 pixels.
- Write/read: write 1 at (1,2), then read (1,2) next cycle -> read_data=1. Read (2,1) -> 0, confirming no x/y swap (index 33 vs 18).
- Second location: write 1 at (4,5), then read (4,5) -> 1. (1,2) still reads 1 and (5,4) reads 0.
- Write-through and clear: write 1 at (15,15) and check read_data=1 on the following cycle. Then write 0 at (15,15) and read -> 0. Also check (0,0) and (15,0) corners.
- Reset priority: hold rst_n=0 while write_enable=1, write_data=1 at (3,3). Release reset and read (3,3) -> 0. Then reset after populating pixels -> all read 0.
- Walking pattern: write 1 to pixels where (x+y) is odd, then read all 256 -> matches the checkerboard with 1-cycle latency on consecutive reads.
